cpu_imem: RTL and testbench

CPU_IMEM -- requirements
Module: cpu_imem

---
 rtl/cpu_imem_pkg.sv | 16 +
 rtl/cpu_imem_if.sv | 27 ++
 rtl/cpu_imem_ram.sv | 26 ++
 rtl/cpu_imem.sv | 116 +++++++++++
 tb/tb_cpu_imem.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_imem_pkg.sv
// rtl/cpu_imem_pkg.sv - shared cpu defines: instruction width, NOP encoding, loader states
package cpu_imem_pkg;

  localparam int INSTR_W = 48;
  localparam logic [INSTR_W-1:0] INSTR_NOP = '0;
  localparam int BYTES_PER_WORD = 6;
  localparam logic [2:0] LAST_BYTE_IDX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RUN    = 2'd3
  } imem_state_e;

endpackage

// File: rtl/cpu_imem_if.sv
// rtl/cpu_imem_if.sv - fetch port and program-load port bundle
interface cpu_imem_if;
  import cpu_imem_pkg::*;

  logic [31:0]        hatch_address;
  logic [INSTR_W-1:0] hatch_instruction;
  logic               cpu_rst_b;
  logic               ld_start;
  logic               ld_valid;
  logic [7:0]         ld_byte;
  logic               ld_last;
  logic               ld_ready;
  logic               ld_ovf;

  // CPU / loader side
  modport master (
    output hatch_address, ld_start, ld_valid, ld_byte, ld_last,
    input  hatch_instruction, cpu_rst_b, ld_ready, ld_ovf
  );

  // instruction memory side
  modport slave (
    input  hatch_address, ld_start, ld_valid, ld_byte, ld_last,
    output hatch_instruction, cpu_rst_b, ld_ready, ld_ovf
  );

endinterface

// File: rtl/cpu_imem_ram.sv
// rtl/cpu_imem_ram.sv - simple dual-port instruction storage, no reset
module cpu_imem_ram #(
  parameter int AW = 10,
  parameter int DW = 48
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  // synchronous write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // synchronous read port
  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/cpu_imem.sv
// rtl/cpu_imem.sv - instruction memory with byte-stream program loader and CPU hold-in-reset
module cpu_imem
  import cpu_imem_pkg::*;
#(
  parameter int IMEM_AW = 10
) (
  input  logic       clk,
  input  logic       rst,
  cpu_imem_if.slave  bus
);

  imem_state_e        r_state;
  imem_state_e        w_next;
  logic [IMEM_AW:0]   r_wr_addr;   // extra MSB marks "past depth-1"; address never wraps
  logic [2:0]         r_byte_cnt;
  logic [INSTR_W-1:0] r_asm;
  logic               r_last;      // word being assembled was closed by ld_last
  logic               r_ovf;
  logic               r_rd_ok;     // address sampled with the read was in range

  logic               w_accept;
  logic               w_wr_en;
  logic               w_ld_ready;
  logic               w_cpu_rst_b;
  logic [5:0]         w_shift;
  logic [INSTR_W-1:0] w_ram_q;
  logic               w_in_range;

  // loader state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // next state and handshake outputs; ld_start overrides everything, including a pending byte
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_wr_en     = 1'b0;
    w_ld_ready  = 1'b0;
    w_cpu_rst_b = (r_state == ST_RUN);
    if (bus.ld_start) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_IDLE;
        ST_LOAD: begin
          w_ld_ready = 1'b1;
          w_accept   = bus.ld_valid;
          if (w_accept && (bus.ld_last || r_byte_cnt == LAST_BYTE_IDX)) w_next = ST_COMMIT;
        end
        ST_COMMIT: begin
          w_wr_en = ~r_wr_addr[IMEM_AW];
          w_next  = r_last ? ST_RUN : ST_LOAD;
        end
        ST_RUN:  w_next = ST_RUN;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // first byte lands in the top lane; lanes never written stay zero because r_asm is cleared per word
  assign w_shift = 6'd40 - {r_byte_cnt, 3'b000};

  // word assembly, write address and overflow tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr  <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_last     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (bus.ld_start) begin
      r_wr_addr  <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_last     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_accept) begin
      r_asm      <= r_asm | ({40'd0, bus.ld_byte} << w_shift);
      r_byte_cnt <= r_byte_cnt + 3'd1;
      r_last     <= bus.ld_last;
    end else if (r_state == ST_COMMIT) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
      if (r_wr_addr[IMEM_AW]) r_ovf <= 1'b1;
      else                    r_wr_addr <= r_wr_addr + {{IMEM_AW{1'b0}}, 1'b1};
    end
  end

  assign w_in_range = ((bus.hatch_address >> IMEM_AW) == 32'd0);

  // remember whether the address travelling with this read was inside the array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_ok <= 1'b0;
    else     r_rd_ok <= w_in_range;
  end

  cpu_imem_ram #(
    .AW (IMEM_AW),
    .DW (INSTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_addr[IMEM_AW-1:0]),
    .i_wdata (r_asm),
    .i_raddr (bus.hatch_address[IMEM_AW-1:0]),
    .o_rdata (w_ram_q)
  );

  assign bus.hatch_instruction = (r_state == ST_RUN && r_rd_ok) ? w_ram_q : INSTR_NOP;
  assign bus.cpu_rst_b         = w_cpu_rst_b;
  assign bus.ld_ready          = w_ld_ready;
  assign bus.ld_ovf            = r_ovf;

endmodule

// File: tb/tb_cpu_imem.sv
// tb/tb_cpu_imem.sv - directed scoreboard bench for cpu_imem
module tb_cpu_imem;

  logic clk;
  logic rst;

  cpu_imem_if ifa ();
  cpu_imem_if ifb ();

  cpu_imem #(.IMEM_AW(10)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  cpu_imem #(.IMEM_AW(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [47:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;
  bit  mon_hi = 1'b0;

  always @(negedge clk) begin
    if (mon_en && ifa.cpu_rst_b) mon_hi <= 1'b1;
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, req);
    end
  endtask

  task automatic drv(input bit sel, input logic st, input logic v, input logic [7:0] b, input logic l);
    if (sel) begin
      ifb.ld_start = st; ifb.ld_valid = v; ifb.ld_byte = b; ifb.ld_last = l;
    end else begin
      ifa.ld_start = st; ifa.ld_valid = v; ifa.ld_byte = b; ifa.ld_last = l;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? ifb.ld_ready : ifa.ld_ready;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    drv(sel, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    drv(sel, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic l);
    logic acc;
    acc = 1'b0;
    drv(sel, 1'b0, 1'b1, b, l);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = rdy(sel);
      step();
    end
    drv(sel, 1'b0, 1'b0, 8'h00, 1'b0);
    if (!acc) chk1("ld_ready_timeout", acc, 1'b1);
  endtask

  task automatic rd(input bit sel, input logic [31:0] addr, input logic [47:0] req, input string tag);
    sb_t e;
    sb_q.push_back('{tag, req});
    if (sel) ifb.hatch_address = addr;
    else     ifa.hatch_address = addr;
    step();
    e = sb_q.pop_front();
    chk(e.tag, sel ? ifb.hatch_instruction : ifa.hatch_instruction, e.val);
  endtask

  initial begin
    logic [47:0] w_exp [0:4];
    rst = 1'b1;
    ifa.hatch_address = '0;
    ifb.hatch_address = '0;
    drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    step();

    chk1("rst_cpu_rst_b", ifa.cpu_rst_b, 1'b0);
    chk1("rst_ld_ready",  ifa.ld_ready,  1'b0);
    chk1("rst_ld_ovf",    ifa.ld_ovf,    1'b0);
    chk ("rst_hatch",     ifa.hatch_instruction, 48'h0);
    rst = 1'b0;
    step();

    // two full words, last byte closes the second one
    pulse_start(1'b0);
    for (int k = 1; k <= 12; k++) send_byte(1'b0, 8'(k), k == 12);
    chk1("commit2_rst_b_low", ifa.cpu_rst_b, 1'b0);
    step();
    chk1("run_rst_b_high", ifa.cpu_rst_b, 1'b1);
    chk1("run_no_ovf", ifa.ld_ovf, 1'b0);
    rd(1'b0, 32'd0, 48'h010203040506, "mem0_first_load");
    rd(1'b0, 32'd1, 48'h0708090A0B0C, "mem1_first_load");
    rd(1'b0, 32'h400, 48'h0, "addr_0x400_nop");
    rd(1'b0, 32'hFFFF_FFFF, 48'h0, "addr_max_nop");

    // short word zero-filled
    pulse_start(1'b0);
    send_byte(1'b0, 8'hAA, 1'b0);
    send_byte(1'b0, 8'hBB, 1'b1);
    step();
    chk1("short_run", ifa.cpu_rst_b, 1'b1);
    rd(1'b0, 32'd0, 48'hAABB00000000, "mem0_short_word");
    rd(1'b0, 32'd1, 48'h0708090A0B0C, "mem1_persists");

    // restart mid-word with a colliding byte
    pulse_start(1'b0);
    mon_hi = 1'b0;
    mon_en = 1'b1;
    send_byte(1'b0, 8'h11, 1'b0);
    send_byte(1'b0, 8'h22, 1'b0);
    send_byte(1'b0, 8'h33, 1'b0);
    drv(1'b0, 1'b1, 1'b1, 8'h44, 1'b0);
    @(negedge clk);
    chk1("start_blocks_ready", ifa.ld_ready, 1'b0);
    step();
    drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 6; k++) send_byte(1'b0, 8'(8'h50 + k), k == 6);
    mon_en = 1'b0;
    chk1("rst_b_low_during_reload", mon_hi, 1'b0);
    step();
    rd(1'b0, 32'd0, 48'h515253545556, "mem0_after_restart");

    // reset in the middle of a load
    pulse_start(1'b0);
    for (int k = 1; k <= 12; k++) send_byte(1'b0, 8'(8'h60 + k), 1'b0);
    for (int k = 1; k <= 4; k++)  send_byte(1'b0, 8'(8'h70 + k), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("midrst_cpu_rst_b", ifa.cpu_rst_b, 1'b0);
    chk1("midrst_ld_ready",  ifa.ld_ready,  1'b0);
    chk1("midrst_ld_ovf",    ifa.ld_ovf,    1'b0);
    chk ("midrst_hatch",     ifa.hatch_instruction, 48'h0);
    step();
    rst = 1'b0;
    drv(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
    @(negedge clk);
    chk1("idle_ld_ready", ifa.ld_ready, 1'b0);
    step();
    drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    pulse_start(1'b0);
    send_byte(1'b0, 8'h99, 1'b1);
    step();
    rd(1'b0, 32'd0, 48'h990000000000, "mem0_after_abort");
    rd(1'b0, 32'd1, 48'h6768696A6B6C, "mem1_survives_rst");

    // small array: fifth word overflows
    pulse_start(1'b1);
    for (int w = 0; w < 5; w++) begin
      w_exp[w] = '0;
      for (int k = 0; k < 6; k++) begin
        w_exp[w] = {w_exp[w][39:0], 8'((w + 1) * 16 + k + 1)};
        send_byte(1'b1, 8'((w + 1) * 16 + k + 1), (w == 4) && (k == 5));
      end
    end
    step();
    chk1("ovf_set", ifb.ld_ovf, 1'b1);
    chk1("ovf_run", ifb.cpu_rst_b, 1'b1);
    for (int w = 0; w < 4; w++) rd(1'b1, 32'(w), w_exp[w], $sformatf("small_mem%0d", w));
    rd(1'b1, 32'd4, 48'h0, "small_addr4_nop");
    pulse_start(1'b1);
    chk1("ovf_cleared_by_start", ifb.ld_ovf, 1'b0);
    chk1("start_holds_cpu", ifb.cpu_rst_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
